// File: rtl/fifo_burst_reader.sv
// Drain side of the prefetch FIFO: pops show-ahead words and emits granted, fixed-length framed bursts.
// Optional macro FIFO_BURST_READER_STAT_EN adds the starve_cnt underrun statistic output.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 32,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_vld,
  output logic                  fifo_rd_en,
  output logic                  burst_req,
  input  logic                  burst_gnt,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  busy,
  output logic [15:0]           burst_done_cnt
`ifdef FIFO_BURST_READER_STAT_EN
  ,
  output logic [15:0]           starve_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t           state;
  logic [CNT_W-1:0] pull_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             can_pull;
  logic             pop;
  logic             accept;

  // A pop is offered only when the output register is free or draining this cycle.
  assign can_pull   = (state == XFER) && (pull_cnt < FULL_CNT) && (!m_valid || m_ready);
  assign fifo_rd_en = can_pull;
  assign pop        = can_pull && fifo_rd_vld;
  assign accept     = m_valid && m_ready;
  assign busy       = (state != IDLE) || m_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pull_cnt       <= '0;
      out_cnt        <= '0;
      burst_req      <= 1'b0;
      m_data         <= '0;
      m_valid        <= 1'b0;
      m_sof          <= 1'b0;
      m_eof          <= 1'b0;
      burst_done_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd_vld) begin
            state     <= REQ;
            burst_req <= 1'b1;
          end
        end
        REQ: begin
          if (burst_gnt) begin
            state     <= XFER;
            burst_req <= 1'b0;
            pull_cnt  <= '0;
            out_cnt   <= '0;
          end
        end
        XFER: begin
          // The burst ends only when its last word leaves, regardless of underrun bubbles.
          if (accept) begin
            if (out_cnt == LAST_IDX) begin
              state          <= IDLE;
              out_cnt        <= '0;
              burst_done_cnt <= burst_done_cnt + 16'd1;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          burst_req <= 1'b0;
        end
      endcase

      if (pop) begin
        m_data   <= fifo_rd_data;
        m_valid  <= 1'b1;
        m_sof    <= (pull_cnt == '0);
        m_eof    <= (pull_cnt == LAST_IDX);
        pull_cnt <= pull_cnt + 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_BURST_READER_STAT_EN
  // Counts cycles where a pop was offered but the FIFO had nothing to give.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (can_pull && !fifo_rd_vld && (starve_cnt != 16'hFFFF)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule
